// File: rtl/neuron_mac.sv
// neuron_mac
//   Multiply-accumulate stage for one neuron. Each accepted input sample
//   drives a read of the neuron's weight memory. The returned weight is
//   multiplied by the aligned sample, and the products are accumulated with
//   saturation over numWeight samples. At the end of each vector the bias is
//   added and one saturated weighted sum is emitted.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid this cycle (no backpressure)
//   in_data    signed input sample
//   bias       signed bias in product Q-format, sampled at the end of a vector
//   ren        weight-memory read enable (combinational)
//   radd       weight-memory read address (combinational, current index)
//   wout       signed weight, returned one cycle after ren
//   out_valid  one-cycle pulse qualifying out_data / out_sat
//   out_data   signed saturated sum of x*w plus bias
//   out_sat    saturation occurred somewhere in this vector
module neuron_mac #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int accWidth     = 2 * dataWidth
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [dataWidth-1:0]    in_data,
  input  logic signed [accWidth-1:0]     bias,
  output logic                           ren,
  output logic        [addressWidth-1:0] radd,
  input  logic signed [dataWidth-1:0]    wout,
  output logic                           out_valid,
  output logic signed [accWidth-1:0]     out_data,
  output logic                           out_sat
);

  localparam int prodWidth = 2 * dataWidth;
  localparam logic [addressWidth-1:0] lastIdx = addressWidth'(numWeight - 1);
  localparam logic signed [accWidth-1:0] accMax = {1'b0, {(accWidth-1){1'b1}}};
  localparam logic signed [accWidth-1:0] accMin = {1'b1, {(accWidth-1){1'b0}}};

  // A one-bit-wider sum has overflowed the accWidth range when its two top
  // bits disagree.
  function automatic logic overflow(input logic signed [accWidth:0] v);
    return v[accWidth] != v[accWidth-1];
  endfunction

  // Clamp a one-bit-wider sum to the signed accWidth range; the top bit gives
  // the true sign, and therefore the direction of the clamp.
  function automatic logic signed [accWidth-1:0] saturate(input logic signed [accWidth:0] v);
    if (overflow(v)) begin
      return v[accWidth] ? accMin : accMax;
    end
    return v[accWidth-1:0];
  endfunction

  // Sample index and pipeline state
  logic        [addressWidth-1:0] cnt_q, cnt_d;
  logic signed [dataWidth-1:0]    x_q;
  logic                           v0_q, first0_q, last0_q;
  logic signed [prodWidth-1:0]    prod_q;
  logic                           v1_q, first1_q, last1_q;
  logic signed [accWidth-1:0]     acc_q;
  logic                           satf_q;
  logic                           outValid_q;
  logic signed [accWidth-1:0]     outData_q;
  logic                           outSat_q;

  // Stage-2 combinational datapath
  logic signed [accWidth-1:0] accBase;
  logic signed [accWidth:0]   prodWide;
  logic signed [accWidth:0]   sumWide;
  logic signed [accWidth-1:0] sumSat;
  logic                       satfNext;
  logic signed [accWidth:0]   biasWide;
  logic signed [accWidth-1:0] biasSat;

  // The memory read is issued in the same cycle the sample arrives, so the
  // weight comes back exactly when the registered sample reaches stage 1.
  assign ren  = in_valid & rst_n;
  assign radd = cnt_q;

  // Index advances only on accepted samples and wraps at the vector end.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = (cnt_q == lastIdx) ? '0 : cnt_q + addressWidth'(1);
    end
  end

  // The first sample of a vector restarts the running sum from zero instead
  // of the stale accumulator, which lets vectors run back to back without a
  // bubble. The bias add reuses the same saturation rule.
  always_comb begin
    accBase = acc_q;
    if (first1_q) begin
      accBase = '0;
    end
    prodWide = (accWidth+1)'(prod_q);
    sumWide  = (accWidth+1)'(accBase) + prodWide;
    sumSat   = saturate(sumWide);
    satfNext = (satf_q & ~first1_q) | overflow(sumWide);
    biasWide = (accWidth+1)'(sumSat) + (accWidth+1)'(bias);
    biasSat  = saturate(biasWide);
  end

  // Three-stage pipeline: capture sample and position tags, multiply by the
  // returned weight, then accumulate and emit on the last sample. A reset
  // discards any partial vector and clears every tag so no stale pulse leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      x_q        <= '0;
      v0_q       <= 1'b0;
      first0_q   <= 1'b0;
      last0_q    <= 1'b0;
      prod_q     <= '0;
      v1_q       <= 1'b0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      acc_q      <= '0;
      satf_q     <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSat_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;

      v0_q     <= in_valid;
      first0_q <= in_valid && (cnt_q == '0);
      last0_q  <= in_valid && (cnt_q == lastIdx);
      if (in_valid) begin
        x_q <= in_data;
      end

      v1_q     <= v0_q;
      first1_q <= first0_q;
      last1_q  <= last0_q;
      if (v0_q) begin
        prod_q <= prodWidth'(x_q) * prodWidth'(wout);
      end

      outValid_q <= v1_q & last1_q;
      if (v1_q) begin
        acc_q  <= sumSat;
        satf_q <= satfNext;
        if (last1_q) begin
          outData_q <= biasSat;
          outSat_q  <= satfNext | overflow(biasWide);
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_sat   = outSat_q;

endmodule
